// File: rtl/add4_seq_ctrl.sv
// Serial WIDTH-bit adder: one 4-bit ripple-carry slice reused over WIDTH/4 cycles.
// Optional signed-overflow output is built when ADD4_OVF_DETECT_EN is defined.
module add4_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef ADD4_OVF_DETECT_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; in_ready is high only in IDLE, out_valid only in DONE.
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nx;
  logic [WIDTH-1:0] opa, opb;
  logic [IW-1:0]   idx;
  logic            carry;
  logic [3:0]      nib_a, nib_b, slice_s;
  logic [4:0]      c;
  logic            slice_c;
  logic            last;

  // Nibble slice with per-bit generate/propagate and a rippled carry.
  always_comb begin
    nib_a   = opa[4*idx +: 4];
    nib_b   = opb[4*idx +: 4];
    c       = '0;
    slice_s = '0;
    c[0]    = carry;
    for (int i = 0; i < 4; i++) begin
      c[i+1]     = (nib_a[i] & nib_b[i]) | ((nib_a[i] ^ nib_b[i]) & c[i]);
      slice_s[i] = nib_a[i] ^ nib_b[i] ^ c[i];
    end
    slice_c = c[4];
    last    = (idx == LAST);
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      opa   <= '0;
      opb   <= '0;
      idx   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef ADD4_OVF_DETECT_EN
      ovf   <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (in_valid) begin
            opa   <= a;
            opb   <= b;
            carry <= cin;
            idx   <= '0;
          end
        end
        RUN: begin
          sum[4*idx +: 4] <= slice_s;
          carry           <= slice_c;
          idx             <= idx + 1'b1;
          if (last) begin
            cout <= slice_c;
`ifdef ADD4_OVF_DETECT_EN
            // slice_s[3] is the final result MSB on the last slice.
            ovf  <= (opa[WIDTH-1] == opb[WIDTH-1]) && (slice_s[3] != opa[WIDTH-1]);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule
